// File: rtl/fixed_float_pkg.sv
// Shared types and constants for the fixed-point <-> IEEE 754 single-precision converters.
// The 65-bit fixed type is sign-magnitude 32.32 and is shared with the float-to-fixed stage.
package fixed_float_pkg;

  localparam int unsigned FIX_INT_W   = 32;
  localparam int unsigned FIX_FRAC_W  = 32;
  localparam int unsigned FIX_MAG_W   = FIX_INT_W + FIX_FRAC_W;
  localparam int unsigned FIX_W       = 1 + FIX_MAG_W;
  localparam int unsigned FP_EXP_BIAS = 127;
  localparam int unsigned FP_MANT_W   = 23;
  localparam int unsigned FP_EXP_W    = 8;

  typedef logic [FIX_W-1:0] fix32_32_t;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } conv_state_t;

  function automatic logic fix_sign(input fix32_32_t value);
    return value[FIX_W-1];
  endfunction

  function automatic logic [FIX_MAG_W-1:0] fix_mag(input fix32_32_t value);
    return value[FIX_MAG_W-1:0];
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational mantissa rounder: round-to-nearest-even (mode = 0) or truncate (mode = 1).
// A mantissa carry-out is folded into the exponent.
module fp_round_rne
  import fixed_float_pkg::*;
(
  input  logic [FP_MANT_W-1:0] mant_in,
  input  logic                 guard,
  input  logic                 sticky,
  input  logic [FP_EXP_W-1:0]  exp_in,
  input  logic                 mode,
  output logic [FP_MANT_W-1:0] mant_out,
  output logic [FP_EXP_W-1:0]  exp_out,
  output logic                 inexact
);

  logic round_up;
  logic carry;

  always_comb begin
    round_up = ~mode & guard & (sticky | mant_in[0]);
    {carry, mant_out} = {1'b0, mant_in} + {{FP_MANT_W{1'b0}}, round_up};
    exp_out = exp_in + {{(FP_EXP_W-1){1'b0}}, carry};
    inexact = guard | sticky;
  end

endmodule

// File: rtl/fixed_32_32_to_ieee_754.sv
// Sign-magnitude 32.32 fixed-point to IEEE 754 single precision, start/done handshake,
// one-bit-per-clock normalisation followed by a single rounding cycle.
module fixed_32_32_to_ieee_754
  import fixed_float_pkg::*;
#(
  parameter int unsigned ROUND_MODE = 0,
  parameter int unsigned FRAC_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [64:0] fixed_point,
  output logic [31:0] IEEE_float,
  output logic        done,
  output logic        busy,
  output logic        inexact
);

  // Biased exponent of the value held in the top magnitude bit.
  localparam logic [FP_EXP_W-1:0] ExpInit =
      FP_EXP_W'(FP_EXP_BIAS + FIX_MAG_W - 1 - FRAC_W);
  localparam logic [FP_EXP_W-1:0] ExpOne   = FP_EXP_W'(1);
  localparam int unsigned         GuardBit = FIX_MAG_W - 2 - FP_MANT_W;
  localparam logic                Truncate = (ROUND_MODE != 0);

  conv_state_t              state_q, state_d;
  logic [FIX_MAG_W-1:0]     mag_q, mag_d;
  logic [FP_EXP_W-1:0]      exp_q, exp_d;
  logic                     sign_q, sign_d;
  logic [31:0]              float_q, float_d;
  logic                     inexact_q, inexact_d;
  logic                     done_q, done_d;

  logic [FIX_MAG_W-1:0]     in_mag;
  logic [FP_MANT_W-1:0]     rnd_mant;
  logic [FP_EXP_W-1:0]      rnd_exp;
  logic                     rnd_inexact;

  assign in_mag = fix_mag(fixed_point);

  fp_round_rne u_round (
    .mant_in  (mag_q[FIX_MAG_W-2 -: FP_MANT_W]),
    .guard    (mag_q[GuardBit]),
    .sticky   (|mag_q[GuardBit-1:0]),
    .exp_in   (exp_q),
    .mode     (Truncate),
    .mant_out (rnd_mant),
    .exp_out  (rnd_exp),
    .inexact  (rnd_inexact)
  );

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    sign_d    = sign_q;
    float_d   = float_q;
    inexact_d = inexact_q;
    done_d    = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_d = fix_sign(fixed_point);
          mag_d  = in_mag;
          exp_d  = ExpInit;
          if (in_mag == '0) begin
            // Zero always converts to +0, whatever the sign bit says.
            float_d   = '0;
            inexact_d = 1'b0;
            state_d   = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mag_q[FIX_MAG_W-1]) begin
          state_d = ROUND;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - ExpOne;
        end
      end
      ROUND: begin
        float_d   = {sign_q, rnd_exp, rnd_mant};
        inexact_d = rnd_inexact;
        state_d   = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      mag_q     <= '0;
      exp_q     <= '0;
      sign_q    <= 1'b0;
      float_q   <= '0;
      inexact_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      sign_q    <= sign_d;
      float_q   <= float_d;
      inexact_q <= inexact_d;
      done_q    <= done_d;
    end
  end

  assign IEEE_float = float_q;
  assign inexact    = inexact_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fixed_32_32_to_ieee_754.sv
// Randomised bench for fixed_32_32_to_ieee_754 with an arithmetic reference model;
// one instance rounds to nearest even, a second instance truncates.
module tb_fixed_32_32_to_ieee_754;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [64:0] fixed_point = '0;
  logic [31:0] f_rne, f_tz;
  logic        done_rne, done_tz, busy_rne, busy_tz, inx_rne, inx_tz;

  always #5 clk = ~clk;

  fixed_32_32_to_ieee_754 #(.ROUND_MODE(0), .FRAC_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .fixed_point(fixed_point),
    .IEEE_float(f_rne), .done(done_rne), .busy(busy_rne), .inexact(inx_rne)
  );

  fixed_32_32_to_ieee_754 #(.ROUND_MODE(1), .FRAC_W(32)) dut_tz (
    .clk(clk), .reset(reset), .start(start), .fixed_point(fixed_point),
    .IEEE_float(f_tz), .done(done_tz), .busy(busy_tz), .inexact(inx_tz)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] f_rne;
    logic [31:0] f_tz;
    logic        inx;
    int unsigned acc;
    int unsigned done_cyc;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Real-number view: value = mag * 2^-32; pick the leading one, round the tail against half an ulp.
  function automatic logic [32:0] model(input logic [64:0] v, input bit trunc);
    logic [63:0] m, keep, rem, half;
    int p, e;
    m = v[63:0];
    if (m == 64'd0) return 33'd0;
    p = 0;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    if (p >= 23) begin
      keep = m >> (p - 23);
      rem  = m & ((64'd1 << (p - 23)) - 64'd1);
    end else begin
      keep = m << (23 - p);
      rem  = 64'd0;
    end
    half = (p >= 24) ? (64'd1 << (p - 24)) : 64'd0;
    e = 127 + p - 32;
    if (!trunc && rem != 0 && (rem > half || (rem == half && keep[0]))) keep = keep + 1;
    if (keep == 64'h100_0000) begin
      keep = keep >> 1;
      e = e + 1;
    end
    return {rem != 64'd0, v[64], 8'(e), keep[22:0]};
  endfunction

  function automatic int unsigned latency(input logic [64:0] v);
    int p;
    if (v[63:0] == 64'd0) return 1;
    p = 0;
    for (int i = 0; i < 64; i++) if (v[i]) p = i;
    return 66 - p;
  endfunction

  task automatic push(input logic [64:0] v, input int unsigned acc);
    exp_t e;
    logic [32:0] r, t;
    r = model(v, 1'b0);
    t = model(v, 1'b1);
    e.f_rne    = r[31:0];
    e.inx      = r[32];
    e.f_tz     = t[31:0];
    e.acc      = acc;
    e.done_cyc = acc + latency(v);
    q.push_back(e);
  endtask

  // Checks handshake and results every cycle against the queue of in-flight expectations.
  exp_t cur;
  logic exp_done, exp_busy;
  always @(negedge clk) begin
    if (reset) begin
      exp_done = (q.size() != 0) && (cyc == q[0].done_cyc);
      exp_busy = (q.size() != 0) && (cyc >= q[0].acc) && (cyc < q[0].done_cyc);
      check("busy", busy_rne, exp_busy);
      check("busy_tz", busy_tz, exp_busy);
      check("done", done_rne, exp_done);
      check("done_tz", done_tz, exp_done);
      if (exp_done) begin
        cur = q.pop_front();
        check("float_rne", f_rne, cur.f_rne);
        check("inexact_rne", inx_rne, cur.inx);
        check("float_tz", f_tz, cur.f_tz);
        check("inexact_tz", inx_tz, cur.inx);
      end
    end
  end

  task automatic issue(input logic [64:0] v);
    @(posedge clk);
    #1 start = 1'b1;
    fixed_point = v;
    @(posedge clk);
    #1 start = 1'b0;
    push(v, cyc);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    if (q.size() != 0) begin
      check("done_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  task automatic convert(input logic [64:0] v);
    issue(v);
    wait_idle();
  endtask

  logic [64:0] dir_v   [7] = '{65'h0_00000001_00000000, 65'h1_00000002_80000000,
                               65'h0_00000000_00000001, 65'h0_00000001_00000100,
                               65'h0_00000001_00000300, 65'h0_FFFFFFFF_FFFFFFFF,
                               65'h1_00000000_00000000};
  logic [31:0] dir_rne [7] = '{32'h3F800000, 32'hC0200000, 32'h2F800000, 32'h3F800000,
                               32'h3F800002, 32'h4F800000, 32'h00000000};
  logic [31:0] dir_tz  [7] = '{32'h3F800000, 32'hC0200000, 32'h2F800000, 32'h3F800000,
                               32'h3F800001, 32'h4F7FFFFF, 32'h00000000};
  logic        dir_inx [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  int unsigned dir_lat [7] = '{34, 33, 66, 34, 34, 3, 1};

  initial begin
    logic [32:0] r;
    logic [63:0] m;
    logic [23:0] k;
    logic [64:0] va, vb;
    int p;
    int unsigned acc;

    repeat (3) @(posedge clk);
    #1;
    check("reset_float", f_rne, 32'h0);
    check("reset_done", done_rne, 1'b0);
    check("reset_busy", busy_rne, 1'b0);
    check("reset_inexact", inx_rne, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      r = model(dir_v[i], 1'b0);
      check("model_rne", r[31:0], dir_rne[i]);
      check("model_inexact", r[32], dir_inx[i]);
      r = model(dir_v[i], 1'b1);
      check("model_tz", r[31:0], dir_tz[i]);
      check("model_latency", latency(dir_v[i]), dir_lat[i]);
      convert(dir_v[i]);
      check("dir_float_rne", f_rne, dir_rne[i]);
      check("dir_float_tz", f_tz, dir_tz[i]);
      check("dir_inexact", inx_rne, dir_inx[i]);
    end

    // start pulsed while busy must be dropped
    issue(65'h0_00000001_00000000);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    fixed_point = 65'h0_12345678_00000000;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    repeat (70) @(posedge clk);
    #1 check("busy_start_ignored", f_rne, 32'h3F800000);

    // start held through done: the second request is taken on the first idle cycle
    va = 65'h0_00000000_00010000;
    vb = 65'h1_00000003_00000000;
    @(posedge clk);
    #1 start = 1'b1;
    fixed_point = va;
    @(posedge clk);
    #1 acc = cyc;
    push(va, acc);
    fixed_point = vb;
    repeat (latency(va)) @(posedge clk);
    #1 push(vb, cyc + 1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    check("held_start_second", f_rne, 32'hC0400000);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 7))
        0: m = 64'd0;
        1, 2: begin
          p = $urandom_range(24, 63);
          k = {1'b1, 23'($urandom())};
          m = (64'(k) << (p - 23)) | (64'd1 << (p - 24));
        end
        default: m = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      endcase
      convert({1'($urandom_range(0, 1)), m});
    end

    // asynchronous reset in the middle of normalisation
    convert(65'h0_00000001_00000000);
    issue(65'h0_00000000_00000001);
    repeat (5) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("abort_float", f_rne, 32'h0);
    check("abort_busy", busy_rne, 1'b0);
    check("abort_done", done_rne, 1'b0);
    check("abort_inexact", inx_rne, 1'b0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (80) @(posedge clk);
    convert(65'h1_00000002_80000000);
    check("after_abort", f_rne, 32'hC0200000);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fixed_32_32_to_ieee_754.md
Name: fixed_32_32_to_ieee_754

Overview:
Converts a 65-bit sign-magnitude 32.32 fixed-point value back into IEEE 754 single precision. It sits directly downstream of the float-to-fixed converter and closes the float -> fixed -> float path used by the arithmetic datapath. It uses a start/done handshake, multi-cycle bit-serial normalisation and round-to-nearest-even.

Parameters:
ROUND_MODE, 0, 0 = round-to-nearest-even, 1 = truncate toward zero
FRAC_W, 32, fraction bits of the input (fixed at 32 for this release; value at bit 0 = 2^-FRAC_W)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request; sampled only in IDLE
fixed_point  input  65  bit 64 = sign, [63:32] = integer magnitude, [31:0] = fraction magnitude
IEEE_float  output  32  converted result; holds until the next conversion completes
done  output  1  one-cycle pulse; IEEE_float is valid in the same cycle
busy  output  1  high in every state except IDLE
inexact  output  1  registered with IEEE_float; 1 if any discarded bit (guard or sticky) was nonzero

Behaviour:
- Reset (reset low, async): state = IDLE, IEEE_float = 0, done = 0, busy = 0, inexact = 0, internal mag/exp/sign cleared.
- States: IDLE, NORM, ROUND, DONE.
- IDLE, start = 1:
  - Latch sign = fixed_point[64] and mag = fixed_point[63:0]; set exp = 158 (bias 127 + 31, position of bit 63).
  - mag == 0 -> DONE with result 0x00000000, always +0, sign ignored.
  - Otherwise -> NORM.
- IDLE, start = 0: remain in IDLE.
- NORM, one step per clock:
  - mag[63] = 1 -> ROUND.
  - Else mag <= mag << 1 and exp <= exp - 1.
- ROUND:
  - Fields: mant = mag[62:40], guard = mag[39], sticky = |mag[38:0].
  - RNE: round up iff guard & (sticky | mant[0]). If mant = all ones and rounding up, then mant = 0 and exp + 1.
  - Truncate mode: never round up.
  - Register IEEE_float = {sign, exp[7:0], mant} and inexact = guard | sticky, then -> DONE.
- DONE: done = 1 for exactly one cycle, then -> IDLE.
- Exponent range:
  - Biased exp is 95..158 before rounding and 159 at most after rounding.
  - Overflow, underflow, subnormals, Inf and NaN cannot occur; no flags exist for them.
- Latency: with L = leading zeros of mag (0..63), done is asserted L+3 clocks after the edge that sampled start. Zero input gives 1 clock.
- start while busy: ignored, not queued; the in-flight conversion is unaffected.
- fixed_point is sampled only on the accepting edge; later input changes have no effect.
- Reset mid-conversion: immediate abort to reset values; no done pulse for the aborted conversion.
- Back-to-back: start may be asserted in the cycle done is high. It is accepted on the edge after done, i.e. the first IDLE cycle.

Decomposition:
- Package fixed_float_pkg holds:
  - FIX_INT_W = 32, FIX_FRAC_W = 32, FP_EXP_BIAS = 127, FP_MANT_W = 23, FP_EXP_W = 8;
  - state enum conv_state_t {IDLE, NORM, ROUND, DONE};
  - 65-bit fixed typedef fix32_32_t, shared with the upstream float-to-fixed converter.
- One sub-module, fp_round_rne: combinational, takes mant/guard/sticky/exp/mode and returns rounded mant, exp and inexact. It is reusable by later float stages.

Test Plan:
- 1.0: fixed_point = 0x0_00000001_00000000, start -> IEEE_float = 0x3F800000, inexact = 0, done 34 clocks after start (L = 31).
- -2.5: fixed_point = 0x1_00000002_80000000 -> 0xC0200000, inexact = 0; smallest value 0x0_00000000_00000001 -> 0x2F800000 after 66 clocks.
- RNE boundaries:
  - 0x0_00000001_00000100 (tie, even) -> 0x3F800000, inexact = 1.
  - 0x0_00000001_00000300 (tie, odd) -> 0x3F800002.
  - 0x0_FFFFFFFF_FFFFFFFF -> 0x4F800000 (mantissa carry into exponent), done after 3 clocks.
  - ROUND_MODE = 1 on the same input -> 0x4F7FFFFF.
- Zero: 0x1_00000000_00000000 -> 0x00000000, done 1 clock after start.
- Handshake:
  - start pulsed during busy -> ignored; exactly one done, result of the first request only.
  - start held high through done -> next conversion begins on the first IDLE cycle.
- Reset low mid-NORM -> IEEE_float = 0 and busy = 0 immediately (asynchronous), no done pulse. A fresh start after release converts correctly.
